// File: rtl/bus_select_rr_pkg.sv
// Shared definitions for the registered N-to-1 bus selector.
package bus_select_rr_pkg;

  // Selection modes; the unused encoding behaves like fixed priority.
  typedef enum logic [1:0] {
    MODE_FIXED = 2'b00,
    MODE_RR    = 2'b01,
    MODE_FORCE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Index width for a channel count, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_select_rr_if.sv
// Source channels plus the one-deep output port of the bus selector.
interface bus_select_rr_if
  import bus_select_rr_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
) ();
  localparam int SEL_W = sel_width(NUM_IN);

  logic [1:0]              mode;
  logic [SEL_W-1:0]        force_sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  // Driver side: sources, mode control and the downstream consumer.
  modport master (
    output mode, force_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Selector side.
  modport slave (
    input  mode, force_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/bus_select_rr_arbiter.sv
// Combinational grant logic: fixed priority, round-robin from ptr, or forced index.
module rr_arbiter
  import bus_select_rr_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  force_sel,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Pick at most one requester; the first hit in search order wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    case (mode)
      MODE_RR: begin
        for (int off = 0; off < NUM_IN; off++) begin
          idx = (int'(ptr) + off) % NUM_IN;
          if (!any_grant && req[idx]) begin
            any_grant = 1'b1;
            grant_idx = SEL_W'(idx);
            grant     = NUM_IN'(1) << idx;
          end
        end
      end
      MODE_FORCE: begin
        // Out-of-range force_sel matches no channel, so nothing is granted.
        for (int i = 0; i < NUM_IN; i++) begin
          if (i == int'(force_sel) && req[i]) begin
            any_grant = 1'b1;
            grant_idx = SEL_W'(i);
            grant     = NUM_IN'(1) << i;
          end
        end
      end
      default: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (!any_grant && req[i]) begin
            any_grant = 1'b1;
            grant_idx = SEL_W'(i);
            grant     = NUM_IN'(1) << i;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/bus_select_rr.sv
// Registered N-to-1 datapath selector with valid/ready on every channel and the output.
module bus_select_rr
  import bus_select_rr_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input logic           clk,
  input logic           rst,
  bus_select_rr_if.slave bus
);

  logic [WIDTH-1:0]  ch_data [NUM_IN];
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_grant;
  logic              load;
  logic              xfer;
  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic [SEL_W-1:0]  rr_ptr_reg;
  logic [SEL_W-1:0]  rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (bus.in_valid),
    .mode      (bus.mode),
    .force_sel (bus.force_sel),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The output register can take a word when empty or being drained this cycle.
  assign load         = !out_valid_reg || bus.out_ready;
  assign xfer         = any_grant && load;
  assign bus.in_ready = (load && !rst) ? grant : '0;
  assign rr_ptr_next  = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;

  // Output register and round-robin pointer; the pointer only moves on round-robin transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
        if (bus.mode == MODE_RR) begin
          rr_ptr_reg <= rr_ptr_next;
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_select_rr.sv
// Scoreboard bench for bus_select_rr: a reference model predicts grants and output words.
module tb_bus_select_rr;
  import bus_select_rr_pkg::*;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_select_rr_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  bus_select_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [SEL_W+WIDTH-1:0] exp_q[$];
  logic                   m_valid;
  logic [WIDTH-1:0]       m_last;
  int                     m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference grant: returns the winning channel or -1.
  function automatic int model_grant(input logic [NUM_IN-1:0] v, input logic [1:0] md,
                                     input logic [SEL_W-1:0] fs, input int ptr);
    if (md == 2'b01) begin
      for (int off = 0; off < NUM_IN; off++) begin
        if (v[(ptr + off) % NUM_IN]) return (ptr + off) % NUM_IN;
      end
    end else if (md == 2'b10) begin
      if (int'(fs) < NUM_IN && v[fs]) return int'(fs);
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (v[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = '0;
    m_ptr   = 0;
  endtask

  task automatic drive(input logic [1:0] md, input logic [SEL_W-1:0] fs,
                       input logic [NUM_IN-1:0] v, input logic r);
    bus.mode      = md;
    bus.force_sel = fs;
    bus.in_valid  = v;
    bus.out_ready = r;
  endtask

  task automatic pattern_data();
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = WIDTH'(i * 16'h1111);
  endtask

  // One clock: inputs already set at the falling edge; check, update model, advance.
  task automatic cycle();
    int                     g;
    logic                   m_load;
    logic [NUM_IN-1:0]      exp_ready;
    logic [SEL_W+WIDTH-1:0] e;
    logic [WIDTH-1:0]       d;
    #1;
    g         = model_grant(bus.in_valid, bus.mode, bus.force_sel, m_ptr);
    m_load    = !m_valid || bus.out_ready;
    exp_ready = (g >= 0 && m_load) ? NUM_IN'(1) << g : '0;
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      check_eq("out_data", 32'(bus.out_data), 32'(e[WIDTH-1:0]));
      check_eq("out_sel", 32'(bus.out_sel), 32'(e[SEL_W+WIDTH-1:WIDTH]));
      if (bus.out_ready) void'(exp_q.pop_front());
    end else if (!m_valid) begin
      check_eq("out_data_retain", 32'(bus.out_data), 32'(m_last));
    end
    if (g >= 0 && m_load) begin
      d = bus.in_data[g*WIDTH +: WIDTH];
      exp_q.push_back({SEL_W'(g), d});
      m_valid = 1'b1;
      m_last  = d;
      if (bus.mode == 2'b01) m_ptr = (g == NUM_IN - 1) ? 0 : g + 1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, '0, 4'hF, 1'b1);
    pattern_data();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
    check_eq("rst_out_sel", 32'(bus.out_sel), 32'h0);
    rst = 1'b0;
    cycle();

    // Fixed priority: channel 1 always wins, channel 3 starves.
    drive(2'b00, '0, 4'b1010, 1'b1);
    repeat (4) cycle();

    // Round-robin over all channels.
    drive(2'b01, '0, 4'hF, 1'b1);
    repeat (8) cycle();

    // Backpressure then release.
    drive(2'b01, '0, 4'hF, 1'b0);
    repeat (3) cycle();
    drive(2'b01, '0, 4'hF, 1'b1);
    repeat (3) cycle();

    // Drain only: output empties, data retained.
    drive(2'b00, '0, 4'h0, 1'b1);
    repeat (2) cycle();

    // Forced channel 2: nothing until it becomes valid.
    drive(2'b10, 2'd2, 4'b0011, 1'b1);
    repeat (2) cycle();
    bus.in_valid = 4'b0111;
    repeat (2) cycle();

    // Reserved mode behaves as fixed priority.
    drive(2'b11, '0, 4'b1100, 1'b1);
    repeat (2) cycle();

    // Asynchronous reset between edges, then round-robin restarts at channel 0.
    drive(2'b01, '0, 4'hF, 1'b1);
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("arst_out_data", 32'(bus.out_data), 32'h0);
    check_eq("arst_out_sel", 32'(bus.out_sel), 32'h0);
    check_eq("arst_in_ready", 32'(bus.in_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) cycle();

    // Random traffic.
    repeat (300) begin
      drive(2'($urandom_range(0, 3)), SEL_W'($urandom_range(0, 3)),
            NUM_IN'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      bus.in_data = {$urandom, $urandom};
      cycle();
    end

    drive(2'b00, '0, 4'h0, 1'b1);
    repeat (2) cycle();
    check_eq("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
